// File: rtl/x_rr_fifo_drain.sv
// Round-robin drain of NSRC FIFOs into one registered valid/ready stream, tagging each word with its source.
// Define X_RR_PKT_LOCK_EN to hold the grant on one source until a word with bit DW-1 (eop) set is popped.
module x_rr_fifo_drain #(
  parameter  int NSRC = 4,
  parameter  int DW   = 8,
  localparam int SW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NSRC-1:0]    src_empty_n,
  output logic [NSRC-1:0]    src_re,
  input  logic [NSRC*DW-1:0] src_dout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      out_data,
  output logic [SW-1:0]      out_src
);

  logic          r_valid;
  logic [DW-1:0] r_data;
  logic [SW-1:0] r_src;
  logic [SW-1:0] r_ptr;

  logic [DW-1:0] w_word [NSRC];
  logic [SW-1:0] w_gnt;
  logic          w_any_req;
  logic          w_load;
  logic          w_pop;

  function automatic logic [SW-1:0] f_wrap(input int v);
    return SW'((v >= NSRC) ? (v - NSRC) : v);
  endfunction

  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_word
      assign w_word[gi] = src_dout[gi*DW +: DW];
    end
  endgenerate

`ifdef X_RR_PKT_LOCK_EN
  typedef enum logic {S_IDLE, S_LOCK} state_t;
  state_t        r_state;
  logic [SW-1:0] r_lock_src;
  logic          w_eop;
`endif

  // Later assignments win, so iterating from the farthest offset down leaves ptr+1 as top priority.
  always_comb begin
    w_gnt     = '0;
    w_any_req = 1'b0;
    for (int i = NSRC; i >= 1; i--) begin
      if (src_empty_n[f_wrap(int'(r_ptr) + i)]) begin
        w_gnt     = f_wrap(int'(r_ptr) + i);
        w_any_req = 1'b1;
      end
    end
`ifdef X_RR_PKT_LOCK_EN
    if (r_state == S_LOCK) begin
      w_gnt     = r_lock_src;
      w_any_req = src_empty_n[r_lock_src];
    end
`endif
  end

  assign w_load = ~r_valid | out_ready;
  assign w_pop  = w_load & w_any_req;

  // Gated by rstn so no FIFO is popped while the whole pipeline is held in reset.
  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_re
      assign src_re[gi] = rstn & w_pop & (w_gnt == SW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_src   <= '0;
      r_ptr   <= SW'(NSRC - 1);
    end else if (w_pop) begin
      r_valid <= 1'b1;
      r_data  <= w_word[w_gnt];
      r_src   <= w_gnt;
      r_ptr   <= w_gnt;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef X_RR_PKT_LOCK_EN
  assign w_eop = w_word[w_gnt][DW-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_lock_src <= '0;
    end else if (w_pop) begin
      case (r_state)
        S_IDLE: begin
          if (!w_eop) begin
            r_state    <= S_LOCK;
            r_lock_src <= w_gnt;
          end
        end
        S_LOCK: begin
          if (w_eop) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`endif

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_src   = r_src;

endmodule

// File: tb/tb_x_rr_fifo_drain.sv
// Bench for x_rr_fifo_drain: queue-backed source FIFOs, a transaction-level reference model,
// directed scenarios followed by a randomized run.
module tb_x_rr_fifo_drain;
  localparam int NSRC = 4;
  localparam int DW   = 8;
  localparam int SW   = 2;
`ifdef X_RR_PKT_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rstn;
  logic [NSRC-1:0]    src_empty_n;
  logic [NSRC-1:0]    src_re;
  logic [NSRC*DW-1:0] src_dout;
  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_data;
  logic [SW-1:0]      out_src;

  always #5 clk = ~clk;

  x_rr_fifo_drain #(.NSRC(NSRC), .DW(DW)) dut (
    .clk(clk), .rstn(rstn), .src_empty_n(src_empty_n), .src_re(src_re),
    .src_dout(src_dout), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src)
  );

  logic [DW-1:0] q [NSRC][$];

  bit            m_valid;
  logic [DW-1:0] m_data;
  int            m_src;
  int            m_ptr;
  bit            m_lock;
  int            m_lock_src;

  int checks;
  int errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void drive_fifos();
    for (int i = 0; i < NSRC; i++) begin
      src_empty_n[i]        = (q[i].size() != 0);
      src_dout[i*DW +: DW]  = (q[i].size() != 0) ? q[i][0] : '0;
    end
  endfunction

  function automatic void model_reset();
    m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = NSRC - 1;
    m_lock = 1'b0; m_lock_src = 0;
  endfunction

  function automatic void clear_fifos();
    for (int i = 0; i < NSRC; i++) q[i].delete();
    drive_fifos();
  endfunction

  function automatic bit pending();
    bit p = m_valid || m_lock;
    for (int i = 0; i < NSRC; i++) if (q[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  // Next source to serve: the locked one, else the first non-empty after the last served.
  task automatic model_grant(output bit any, output int g);
    any = 1'b0; g = 0;
    if (m_lock) begin
      any = (q[m_lock_src].size() != 0);
      g   = m_lock_src;
    end else begin
      for (int k = 1; k <= NSRC; k++) begin
        if (!any && q[(m_ptr + k) % NSRC].size() != 0) begin
          any = 1'b1;
          g   = (m_ptr + k) % NSRC;
        end
      end
    end
  endtask

  task automatic step(input bit rdy, input string tag);
    bit              any;
    int              g;
    bit              pop;
    logic [NSRC-1:0] exp_re;
    logic [NSRC-1:0] re_seen;
    logic [DW-1:0]   w;
    @(negedge clk);
    out_ready = rdy;
    drive_fifos();
    #1;
    model_grant(any, g);
    pop    = (!m_valid || rdy) && any;
    exp_re = '0;
    if (pop) exp_re[g] = 1'b1;
    chk({tag, ".src_re"}, 32'(src_re), 32'(exp_re));
    re_seen = src_re;
    @(posedge clk);
    if (pop) begin
      w       = q[g][0];
      m_valid = 1'b1;
      m_data  = w;
      m_src   = g;
      m_ptr   = g;
      if (LOCK_EN) begin
        if (!m_lock && !w[DW-1]) begin
          m_lock     = 1'b1;
          m_lock_src = g;
        end else if (m_lock && w[DW-1]) begin
          m_lock = 1'b0;
        end
      end
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    for (int i = 0; i < NSRC; i++)
      if (re_seen[i] && q[i].size() != 0) void'(q[i].pop_front());
    #1;
    drive_fifos();
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".out_data"}, 32'(out_data), 32'(m_data));
    chk({tag, ".out_src"}, 32'(out_src), 32'(m_src));
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 40 && pending(); n++) step(1'b1, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rstn = 1'b0;
    out_ready = 1'b0;
    model_reset();

    // T1: reset held with every FIFO non-empty.
    for (int i = 0; i < NSRC; i++) q[i].push_back(8'h80 | 8'(i));
    drive_fifos();
    #12;
    chk("t1.rst_src_re", 32'(src_re), 32'h0);
    chk("t1.rst_valid", 32'(out_valid), 32'h0);
    chk("t1.rst_data", 32'(out_data), 32'h0);
    chk("t1.rst_src", 32'(out_src), 32'h0);
    @(posedge clk); #1; rstn = 1'b1;
    step(1'b1, "t1.first");
    chk("t1.first_src0", 32'(out_src), 32'h0);
    drain("t1.drain");

    // T2: two words per FIFO, continuous ready.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NSRC; i++) q[i].push_back(8'h80 | 8'(r * 16 + i));
    for (int n = 0; n < 2 * NSRC; n++) begin
      step(1'b1, "t2");
      chk("t2.seq_src", 32'(out_src), 32'(n % NSRC));
    end
    step(1'b1, "t2.tail");
    chk("t2.tail_valid", 32'(out_valid), 32'h0);

    // T3: backpressure for five cycles, then release.
    q[0].push_back(8'hA1); q[1].push_back(8'hB2); q[3].push_back(8'hC3);
    step(1'b1, "t3.load");
    for (int n = 0; n < 5; n++) step(1'b0, "t3.hold");
    step(1'b1, "t3.release");
    chk("t3.release_valid", 32'(out_valid), 32'h1);
    drain("t3.drain");

    // T4: only source 2 has data.
    q[2].push_back(8'h11); q[2].push_back(8'h22);
    step(1'b1, "t4.a");
    chk("t4.a_data", 32'(out_data), 32'h11);
    chk("t4.a_src", 32'(out_src), 32'h2);
    step(1'b1, "t4.b");
    chk("t4.b_data", 32'(out_data), 32'h22);
    chk("t4.b_src", 32'(out_src), 32'h2);
    q[2].push_back(8'h80);
    drain("t4.drain");

`ifdef X_RR_PKT_LOCK_EN
    // T5: packet on source 1 keeps source 0 waiting, including across an empty gap.
    q[0].push_back(8'h80);
    step(1'b1, "t5.prime");
    q[1].push_back(8'h01); q[1].push_back(8'h02); q[0].push_back(8'h85);
    step(1'b1, "t5.w0");
    chk("t5.w0_src", 32'(out_src), 32'h1);
    step(1'b1, "t5.w1");
    chk("t5.w1_src", 32'(out_src), 32'h1);
    step(1'b1, "t5.gap0");
    step(1'b1, "t5.gap1");
    chk("t5.gap_valid", 32'(out_valid), 32'h0);
    q[1].push_back(8'h83);
    step(1'b1, "t5.w2");
    chk("t5.w2_src", 32'(out_src), 32'h1);
    step(1'b1, "t5.other");
    chk("t5.other_src", 32'(out_src), 32'h0);
    chk("t5.other_data", 32'(out_data), 32'h85);
    drain("t5.drain");
`endif

    // T6: asynchronous reset while a word is held.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NSRC; i++) q[i].push_back(8'h90 | 8'(r * 4 + i));
    for (int n = 0; n < 3; n++) step(1'b1, "t6.run");
    chk("t6.pre_valid", 32'(out_valid), 32'h1);
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    chk("t6.async_valid", 32'(out_valid), 32'h0);
    chk("t6.async_data", 32'(out_data), 32'h0);
    chk("t6.async_re", 32'(src_re), 32'h0);
    model_reset();
    clear_fifos();
    @(posedge clk); #1; rstn = 1'b1;
    for (int i = 0; i < NSRC; i++) q[i].push_back(8'hE0 | 8'(i));
    step(1'b1, "t6.restart");
    chk("t6.restart_src", 32'(out_src), 32'h0);
    drain("t6.drain");

    // Randomized traffic with random backpressure.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NSRC; i++)
        if ($urandom_range(2) == 0 && q[i].size() < 4) q[i].push_back(8'($urandom));
      step($urandom_range(3) != 0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
